// File: rtl/paint_display_pipeline_if.sv
// Display bus for paint_display_pipeline: layer inputs, fetch address, VGA pins.
// master = the display pipeline, slave = canvas/cursor sources and the DAC side.
interface paint_display_pipeline_if #(
    parameter int WIDTH       = 640,
    parameter int HEIGHT      = 480,
    parameter int COLOR_WIDTH = 3
);
    localparam int XW = $clog2(WIDTH);
    localparam int YW = $clog2(HEIGHT);

    logic                   color_toggle;
    logic [COLOR_WIDTH-1:0] current_color;
    logic [7:0]             camera_r;
    logic [7:0]             camera_g;
    logic [7:0]             camera_b;
    logic [COLOR_WIDTH-1:0] cursor_color;
    logic                   cursor_visible;
    logic [COLOR_WIDTH-1:0] canvas1_color;
    logic                   canvas1_visible;
    logic [COLOR_WIDTH-1:0] canvas2_color;
    logic                   canvas2_visible;
    logic [COLOR_WIDTH-1:0] canvas3_color;
    logic                   canvas3_visible;
    logic [COLOR_WIDTH-1:0] canvas4_color;
    logic                   canvas4_visible;
    logic [XW-1:0]          request_x;
    logic [YW-1:0]          request_y;
    logic [7:0]             VGA_R;
    logic [7:0]             VGA_G;
    logic [7:0]             VGA_B;
    logic                   VGA_CLK;
    logic                   VGA_HS;
    logic                   VGA_VS;
    logic                   VGA_BLANK_n;
    logic                   VGA_SYNC_n;

    modport master (
        input  color_toggle, camera_r, camera_g, camera_b,
        input  cursor_color, cursor_visible,
        input  canvas1_color, canvas1_visible, canvas2_color, canvas2_visible,
        input  canvas3_color, canvas3_visible, canvas4_color, canvas4_visible,
        output current_color, request_x, request_y,
        output VGA_R, VGA_G, VGA_B, VGA_CLK, VGA_HS, VGA_VS,
        output VGA_BLANK_n, VGA_SYNC_n
    );

    modport slave (
        output color_toggle, camera_r, camera_g, camera_b,
        output cursor_color, cursor_visible,
        output canvas1_color, canvas1_visible, canvas2_color, canvas2_visible,
        output canvas3_color, canvas3_visible, canvas4_color, canvas4_visible,
        input  current_color, request_x, request_y,
        input  VGA_R, VGA_G, VGA_B, VGA_CLK, VGA_HS, VGA_VS,
        input  VGA_BLANK_n, VGA_SYNC_n
    );
endinterface

// File: rtl/paint_display_pipeline.sv
// Paint system display back-end: brush colour selector, layer compositor
// and 640x480@60 VGA timing from a 50 MHz clock (pixel rate clk/2).
module paint_display_pipeline #(
    parameter int WIDTH       = 640,
    parameter int HEIGHT      = 480,
    parameter int COLOR_WIDTH = 3
) (
    input logic clk,
    input logic reset_n,
    paint_display_pipeline_if.master bus
);
    localparam int XW = $clog2(WIDTH);
    localparam int YW = $clog2(HEIGHT);
    localparam int HW = $clog2(WIDTH + 160);
    localparam int VW = $clog2(HEIGHT + 45);

    localparam logic [HW-1:0] H_ACT = HW'(WIDTH);
    localparam logic [HW-1:0] H_SYNC_BEG = HW'(WIDTH + 16);
    localparam logic [HW-1:0] H_SYNC_END = HW'(WIDTH + 111);
    localparam logic [HW-1:0] H_MAX = HW'(WIDTH + 159);
    localparam logic [VW-1:0] V_ACT = VW'(HEIGHT);
    localparam logic [VW-1:0] V_SYNC_BEG = VW'(HEIGHT + 10);
    localparam logic [VW-1:0] V_SYNC_END = VW'(HEIGHT + 11);
    localparam logic [VW-1:0] V_MAX = VW'(HEIGHT + 44);

    localparam logic [COLOR_WIDTH-1:0] COLOR_FIRST = COLOR_WIDTH'(1);
    localparam logic [COLOR_WIDTH-1:0] COLOR_LAST = COLOR_WIDTH'(7);

    logic [COLOR_WIDTH-1:0] color;
    logic                   toggle_prev;

    // Brush colour cycles 1..7 on each rising edge of the toggle level.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            color       <= COLOR_FIRST;
            toggle_prev <= 1'b0;
        end else begin
            toggle_prev <= bus.color_toggle;
            if (bus.color_toggle && !toggle_prev) begin
                color <= (color == COLOR_LAST) ? COLOR_FIRST
                                               : color + COLOR_WIDTH'(1);
            end
        end
    end

    assign bus.current_color = color;

    logic [COLOR_WIDTH-1:0] sel;
    logic [23:0]            pixel;

    always_comb begin
        sel = '0;
        if (bus.cursor_visible && bus.cursor_color != '0)
            sel = bus.cursor_color;
        else if (bus.canvas4_visible && bus.canvas4_color != '0)
            sel = bus.canvas4_color;
        else if (bus.canvas3_visible && bus.canvas3_color != '0)
            sel = bus.canvas3_color;
        else if (bus.canvas2_visible && bus.canvas2_color != '0)
            sel = bus.canvas2_color;
        else if (bus.canvas1_visible && bus.canvas1_color != '0)
            sel = bus.canvas1_color;
    end

    // Index 0 (no layer won) falls through to the camera background.
    always_comb begin
        pixel = {bus.camera_r, bus.camera_g, bus.camera_b};
        case (int'(sel))
            1:       pixel = 24'h000000;
            2:       pixel = 24'hFFFFFF;
            3:       pixel = 24'hFF0000;
            4:       pixel = 24'h00FF00;
            5:       pixel = 24'h0000FF;
            6:       pixel = 24'hFFFF00;
            7:       pixel = 24'hFF00FF;
            default: pixel = {bus.camera_r, bus.camera_g, bus.camera_b};
        endcase
    end

    logic          pix_en;
    logic [HW-1:0] hcount;
    logic [VW-1:0] vcount;
    logic          active;
    logic          hs;
    logic          vs;
    logic [23:0]   rgb_q;
    logic          hs_q;
    logic          vs_q;
    logic          blank_q;

    assign active = (hcount < H_ACT) && (vcount < V_ACT);
    assign hs = !((hcount >= H_SYNC_BEG) && (hcount <= H_SYNC_END));
    assign vs = !((vcount >= V_SYNC_BEG) && (vcount <= V_SYNC_END));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pix_en  <= 1'b0;
            hcount  <= '0;
            vcount  <= '0;
            rgb_q   <= '0;
            hs_q    <= 1'b1;
            vs_q    <= 1'b1;
            blank_q <= 1'b0;
        end else begin
            pix_en <= !pix_en;
            if (pix_en) begin
                if (hcount == H_MAX) begin
                    hcount <= '0;
                    vcount <= (vcount == V_MAX) ? '0 : vcount + 1'b1;
                end else begin
                    hcount <= hcount + 1'b1;
                end
                rgb_q   <= active ? pixel : 24'h000000;
                hs_q    <= hs;
                vs_q    <= vs;
                blank_q <= active;
            end
        end
    end

    // Fetch address is clamped outside the active window.
    assign bus.request_x = active ? hcount[XW-1:0] : '0;
    assign bus.request_y = active ? vcount[YW-1:0] : '0;

    assign bus.VGA_R       = rgb_q[23:16];
    assign bus.VGA_G       = rgb_q[15:8];
    assign bus.VGA_B       = rgb_q[7:0];
    assign bus.VGA_CLK     = pix_en;
    assign bus.VGA_HS      = hs_q;
    assign bus.VGA_VS      = vs_q;
    assign bus.VGA_BLANK_n = blank_q;
    assign bus.VGA_SYNC_n  = 1'b0;
endmodule

// File: tb/tb_paint_display_pipeline.sv
// Scoreboard bench for paint_display_pipeline: 8x8 instance for function,
// plus a 640x480 instance for full-size line timing.
module tb_paint_display_pipeline;
    localparam int W  = 8;
    localparam int H  = 8;
    localparam int CW = 3;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #10 clk = ~clk;

    paint_display_pipeline_if #(.WIDTH(W), .HEIGHT(H), .COLOR_WIDTH(CW)) a ();
    paint_display_pipeline_if #(.WIDTH(640), .HEIGHT(480), .COLOR_WIDTH(CW)) b ();

    paint_display_pipeline #(.WIDTH(W), .HEIGHT(H), .COLOR_WIDTH(CW)) dut (
        .clk(clk), .reset_n(reset_n), .bus(a)
    );
    paint_display_pipeline #(.WIDTH(640), .HEIGHT(480), .COLOR_WIDTH(CW)) dut_full (
        .clk(clk), .reset_n(reset_n), .bus(b)
    );

    int checks = 0;
    int errors = 0;
    string       sb_name[$];
    logic [24:0] sb_exp[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        errors++;
        $display("FAIL %s: got timeout expected event", name);
    endtask

    task automatic push_px(input string name, input logic blank, input logic [23:0] rgb);
        sb_name.push_back(name);
        sb_exp.push_back({blank, rgb});
    endtask

    // Monitor: a pending expectation is matched against the output update
    // that follows a cycle with VGA_CLK high.
    initial begin : monitor
        logic        nxt;
        logic [24:0] e;
        string       n;
        forever begin
            @(negedge clk);
            nxt = a.VGA_CLK;
            @(posedge clk);
            #1;
            if (nxt && sb_exp.size() > 0) begin
                e = sb_exp.pop_front();
                n = sb_name.pop_front();
                check({n, "_rgb"}, 32'({a.VGA_R, a.VGA_G, a.VGA_B}), 32'(e[23:0]));
                check({n, "_blank"}, 32'(a.VGA_BLANK_n), 32'(e[24]));
                check({n, "_sync_n"}, 32'(a.VGA_SYNC_n), 32'h0);
            end
        end
    end

    function automatic logic cond(input int kind);
        case (kind)
            0: return a.VGA_CLK && a.request_x != 3'd0 && a.request_x < 3'd7;
            1: return a.VGA_CLK && a.request_x == 3'd4 && a.request_y == 3'd2;
            2: return a.VGA_CLK && !a.VGA_HS;
            3: return !a.VGA_HS;
            default: return a.VGA_HS;
        endcase
    endfunction

    task automatic wait_cond(input int kind, input int lim, output bit ok);
        int n = 0;
        ok = 1'b0;
        while (!ok && n < lim) begin
            @(negedge clk);
            n++;
            ok = cond(kind);
        end
    endtask

    task automatic issue(input string name, input logic [23:0] rgb);
        bit ok;
        wait_cond(0, 20000, ok);
        if (!ok) begin
            fail_now({name, "_wait"});
        end else begin
            push_px(name, 1'b1, rgb);
            @(posedge clk);
            #2;
        end
    endtask

    function automatic logic sig(input int s);
        case (s)
            0: return a.VGA_HS;
            1: return a.VGA_VS;
            2: return !a.VGA_BLANK_n;
            3: return b.VGA_HS;
            default: return !b.VGA_BLANK_n;
        endcase
    endfunction

    // low = clk cycles low after a falling edge, per = fall-to-fall period.
    task automatic measure(input int s, input int lim, output int low, output int per);
        logic p;
        logic c;
        int   t = 0;
        bit   go = 1'b0;
        low = -1;
        per = -1;
        p = sig(s);
        while (!go && t < lim) begin
            @(posedge clk);
            #1;
            t++;
            c = sig(s);
            go = p && !c;
            p = c;
        end
        t = 0;
        while (go && per < 0 && t < lim) begin
            @(posedge clk);
            #1;
            t++;
            c = sig(s);
            if (!p && c && low < 0) low = t;
            if (p && !c) per = t;
            p = c;
        end
    endtask

    task automatic clear_layers();
        a.cursor_color = 3'd0;  a.cursor_visible = 1'b0;
        a.canvas1_color = 3'd0; a.canvas1_visible = 1'b0;
        a.canvas2_color = 3'd0; a.canvas2_visible = 1'b0;
        a.canvas3_color = 3'd0; a.canvas3_visible = 1'b0;
        a.canvas4_color = 3'd0; a.canvas4_visible = 1'b0;
    endtask

    int cseq[8] = '{2, 3, 4, 5, 6, 7, 1, 2};

    initial begin : stim
        bit ok;
        int hs_lo, hs_per, vs_lo, vs_per, bl_hi, bl_per;
        int fhs_lo, fhs_per, fbl_hi, fbl_per;

        a.color_toggle = 1'b0;
        a.camera_r = 8'h00; a.camera_g = 8'hAA; a.camera_b = 8'hAA;
        clear_layers();
        b.color_toggle = 1'b0;
        b.camera_r = 8'h00; b.camera_g = 8'h00; b.camera_b = 8'h00;
        b.cursor_color = 3'd0;  b.cursor_visible = 1'b0;
        b.canvas1_color = 3'd0; b.canvas1_visible = 1'b0;
        b.canvas2_color = 3'd0; b.canvas2_visible = 1'b0;
        b.canvas3_color = 3'd0; b.canvas3_visible = 1'b0;
        b.canvas4_color = 3'd0; b.canvas4_visible = 1'b0;

        repeat (3) @(negedge clk);
        check("rst_color", 32'(a.current_color), 32'd1);
        check("rst_hs", 32'(a.VGA_HS), 32'd1);
        check("rst_vs", 32'(a.VGA_VS), 32'd1);
        check("rst_blank", 32'(a.VGA_BLANK_n), 32'd0);
        check("rst_rgb", 32'({a.VGA_R, a.VGA_G, a.VGA_B}), 32'd0);
        check("rst_vga_clk", 32'(a.VGA_CLK), 32'd0);
        reset_n = 1'b1;

        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            a.color_toggle = 1'b1;
            @(negedge clk);
            a.color_toggle = 1'b0;
            check($sformatf("color_step%0d", i), 32'(a.current_color), 32'(cseq[i]));
        end
        @(negedge clk);
        a.color_toggle = 1'b1;
        repeat (10) @(negedge clk);
        a.color_toggle = 1'b0;
        @(negedge clk);
        check("color_hold", 32'(a.current_color), 32'd3);

        a.cursor_color = 3'd3;  a.cursor_visible = 1'b1;
        a.canvas1_color = 3'd5; a.canvas1_visible = 1'b1;
        issue("prio_cursor", 24'hFF0000);
        a.cursor_visible = 1'b0;
        issue("prio_canvas1", 24'h0000FF);
        a.canvas1_color = 3'd0;
        issue("prio_camera", 24'h00AAAA);
        a.canvas2_color = 3'd4; a.canvas2_visible = 1'b1;
        a.canvas4_color = 3'd6; a.canvas4_visible = 1'b1;
        issue("order_c4", 24'hFFFF00);
        a.canvas4_visible = 1'b0;
        issue("order_c2", 24'h00FF00);
        a.canvas3_color = 3'd7; a.canvas3_visible = 1'b1;
        issue("order_c3", 24'hFF00FF);
        a.cursor_color = 3'd2; a.cursor_visible = 1'b1;
        issue("cursor_white", 24'hFFFFFF);
        a.cursor_color = 3'd1;
        issue("cursor_black", 24'h000000);
        a.cursor_color = 3'd0;
        issue("cursor_zero", 24'hFF00FF);

        clear_layers();
        wait_cond(1, 20000, ok);
        if (!ok) begin
            fail_now("req_wait");
        end else begin
            repeat (2) @(negedge clk);
            check("req_x", 32'(a.request_x), 32'd5);
            check("req_y", 32'(a.request_y), 32'd2);
            a.cursor_color = 3'd5; a.cursor_visible = 1'b1;
            push_px("req_px", 1'b1, 24'h0000FF);
            @(posedge clk);
            #2;
        end

        a.cursor_color = 3'd3; a.cursor_visible = 1'b1;
        wait_cond(2, 1000, ok);
        if (!ok) begin
            fail_now("blank_wait");
        end else begin
            check("blank_req_x", 32'(a.request_x), 32'd0);
            check("blank_req_y", 32'(a.request_y), 32'd0);
            push_px("blank_px", 1'b0, 24'h000000);
            @(posedge clk);
            #2;
        end

        fork
            measure(0, 1000, hs_lo, hs_per);
            measure(1, 40000, vs_lo, vs_per);
            measure(2, 20000, bl_hi, bl_per);
            measure(3, 4000, fhs_lo, fhs_per);
            measure(4, 4000, fbl_hi, fbl_per);
        join
        check("hs_low", 32'(hs_lo), 32'd192);
        check("hs_period", 32'(hs_per), 32'd336);
        check("vs_low", 32'(vs_lo), 32'd672);
        check("vs_period", 32'(vs_per), 32'd17808);
        check("blank_high", 32'(bl_hi), 32'd16);
        check("full_hs_low", 32'(fhs_lo), 32'd192);
        check("full_hs_period", 32'(fhs_per), 32'd1600);
        check("full_blank_high", 32'(fbl_hi), 32'd1280);
        check("full_blank_period", 32'(fbl_per), 32'd1600);
        check("full_sync_n", 32'(b.VGA_SYNC_n), 32'd0);

        wait_cond(4, 1000, ok);
        if (ok) wait_cond(3, 1000, ok);
        if (!ok) begin
            fail_now("hs_fall_wait");
        end else begin
            repeat (150) @(negedge clk);
            check("pre_rst_hs", 32'(a.VGA_HS), 32'd0);
            #5 reset_n = 1'b0;
            #1;
            check("arst_hs", 32'(a.VGA_HS), 32'd1);
            check("arst_vs", 32'(a.VGA_VS), 32'd1);
            check("arst_blank", 32'(a.VGA_BLANK_n), 32'd0);
            check("arst_rgb", 32'({a.VGA_R, a.VGA_G, a.VGA_B}), 32'd0);
            check("arst_vga_clk", 32'(a.VGA_CLK), 32'd0);
            check("arst_color", 32'(a.current_color), 32'd1);
            check("arst_full_hs", 32'(b.VGA_HS), 32'd1);
            #2 reset_n = 1'b1;
            @(negedge clk);
            check("post_rst_vga_clk", 32'(a.VGA_CLK), 32'd1);
            check("post_rst_req_x", 32'(a.request_x), 32'd0);
            check("post_rst_req_y", 32'(a.request_y), 32'd0);
            a.cursor_color = 3'd4; a.cursor_visible = 1'b1;
            push_px("first_px", 1'b1, 24'h00FF00);
            @(posedge clk);
            #2;
        end

        repeat (4) @(negedge clk);
        check("sb_drained", 32'(sb_exp.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/paint_display_pipeline.md
Name: paint_display_pipeline

Overview:
Display back-end of the paint system. It owns the brush colour selector, composites the cursor, four canvas layers and a camera background into one RGB pixel, and generates 640x480@60 VGA timing from the 50 MHz clock. It drives request_x/request_y so the canvas memories and cursor renderer can supply pixel data for the current scan position.

Parameters:
WIDTH, 640, active pixels per line.
HEIGHT, 480, active lines per frame.
COLOR_WIDTH, 3, palette index width; index 0 = COLOR_NONE (transparent).

Ports:
clk  in  1  50 MHz system clock.
reset_n  in  1  asynchronous, active-low reset.
color_toggle  in  1  level input, already synchronised; each rising edge advances the brush colour.
current_color  out  COLOR_WIDTH  selected brush colour index.
camera_r/camera_g/camera_b  in  8 each  background RGB.
cursor_color  in  COLOR_WIDTH  cursor-layer palette index.
cursor_visible  in  1  cursor layer enable.
canvasN_color  in  COLOR_WIDTH  canvas N palette index, N=1..4.
canvasN_visible  in  1  canvas N enable, N=1..4.
request_x  out  clog2(WIDTH)  column currently being fetched.
request_y  out  clog2(HEIGHT)  row currently being fetched.
VGA_R/VGA_G/VGA_B  out  8 each  pixel colour.
VGA_CLK  out  1  25 MHz pixel clock, clk/2.
VGA_HS, VGA_VS  out  1  syncs, active low.
VGA_BLANK_n  out  1  high during the active region.
VGA_SYNC_n  out  1  tied to 0.

Behaviour:
- Palette, combinational:
  - 1 = 000000
  - 2 = FFFFFF
  - 3 = FF0000
  - 4 = 00FF00
  - 5 = 0000FF
  - 6 = FFFF00
  - 7 = FF00FF
- Colour selector:
  - Registers the previous value of color_toggle.
  - On a rising edge, current_color advances 1→2→…→7→1. It never takes the value 0.
  - Holding the input high does not cause further steps.
  - Reset sets current_color=1 and the previous-value register to 0.
- Compositor, purely combinational. A layer wins if it is visible and its colour is nonzero. Priority from highest: cursor, canvas4, canvas3, canvas2, canvas1. If no layer wins, output the camera RGB. The selected palette index is mapped through the palette.
- Pixel enable: pix_en toggles every clk. VGA_CLK equals pix_en, so VGA_CLK rises on cycles where the counters update.
- Counters: hcount 0..WIDTH+159 and vcount 0..HEIGHT+44.
  - hcount advances on each pix_en.
  - On hcount wrap, vcount advances; vcount wraps after its maximum.
- Horizontal timing: front porch 16, sync 96, back porch 48. VGA_HS is low for hcount in [WIDTH+16, WIDTH+111].
- Vertical timing: front porch 10, sync 2, back porch 33. VGA_VS is low for vcount in [HEIGHT+10, HEIGHT+11].
- Active region is hcount<WIDTH and vcount<HEIGHT.
- request_x/request_y equal hcount/vcount in the active region. Outside it they are clamped to 0, so they never address beyond the limits.
- Output registers:
  - On each pix_en, the composited RGB, HS, VS and active flag are registered into VGA_R/G/B, VGA_HS, VGA_VS and VGA_BLANK_n.
  - This gives a one-pixel latency, aligned across all signals.
  - VGA_R/G/B are forced to 0 when not active.
- Reset values (asynchronous): hcount=0, vcount=0, pix_en=0, VGA_CLK=0, VGA_R/G/B=0, VGA_HS=1, VGA_VS=1, VGA_BLANK_n=0.
- Reset mid-frame restarts the frame at (0,0) with no partial sync pulse.
- Small WIDTH/HEIGHT (e.g. 8x8) must elaborate and run with the same porch and sync constants.

Test Plan:
- Colour cycling: hold reset_n=0, then release; apply 8 single-cycle color_toggle pulses → current_color goes 1,2,3,4,5,6,7,1,2. Hold toggle high for 10 cycles → exactly one step.
- Priority: cursor=3 visible, canvas1=5 visible → FF0000. Set cursor_visible=0 → 0000FF. Set canvas1_color=0 → camera 00AAAA.
- Layer order: canvas2=4, canvas4=6, both visible → FFFF00. Set canvas4_visible=0 → 00FF00.
- Timing at 640x480: HS period 1600 clk with 192 clk low; VS period 1600*525 clk with 2 lines low; VGA_BLANK_n high for 1280 clk per line; VGA_SYNC_n=0 throughout.
- Request/latency: at hcount=5, vcount=2, request_x=5 and request_y=2. The composited colour for that request appears on VGA_R/G/B at the next pix_en. Outside the active region, request_x/request_y=0 and RGB=0.
- Async reset mid-line: assert reset_n=0 at hcount=300 without a clk edge → outputs take reset values immediately. After release, the first active pixel is (0,0).
